// File: rtl/serial_add_arb.sv
// serial_add_arb: two-requester, round-robin-arbitrated bit-serial adder.
// A single full-adder cell (two chained half adders) is shared by both
// requesters and is stepped LSB-first over WIDTH cycles per operation.
module serial_add_arb #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic             r_last;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_c;
  logic [CW-1:0]    r_cnt;
  logic             r_gnt0;
  logic             r_gnt1;
  logic             r_done;
  logic             r_done_id;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic             w_any;
  logic             w_win;
  logic             w_last_bit;
  logic             w_ha1_s;
  logic             w_ha1_c;
  logic             w_s;
  logic             w_ha2_c;
  logic             w_cn;

  // Round-robin: on a tie the requester that was not served last wins;
  // a lone request wins regardless of history.
  assign w_any      = req0 | req1;
  assign w_win      = (req0 & req1) ? ~r_last : req1;
  assign w_last_bit = (r_cnt == LAST_BIT);

  // Shared full-adder cell built from two half adders.
  assign w_ha1_s = r_a[0] ^ r_b[0];
  assign w_ha1_c = r_a[0] & r_b[0];
  assign w_s     = w_ha1_s ^ r_c;
  assign w_ha2_c = w_ha1_s & r_c;
  assign w_cn    = w_ha1_c | w_ha2_c;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: IDLE -> RUN on any request, RUN -> DONE after the
  // last bit, DONE always returns to IDLE.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_any) w_next = S_RUN;
      S_RUN:   if (w_last_bit) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output decode from state.
  always_comb begin
    busy = (r_state != S_IDLE);
  end

  // Operand capture, serial datapath and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last    <= 1'b1;
      r_a       <= '0;
      r_b       <= '0;
      r_res     <= '0;
      r_c       <= 1'b0;
      r_cnt     <= '0;
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_done    <= 1'b0;
      r_done_id <= 1'b0;
      r_sum     <= '0;
      r_cout    <= 1'b0;
    end else begin
      r_gnt0 <= 1'b0;
      r_gnt1 <= 1'b0;
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_a       <= w_win ? a1 : a0;
            r_b       <= w_win ? b1 : b0;
            r_res     <= '0;
            r_c       <= 1'b0;
            r_cnt     <= '0;
            r_last    <= w_win;
            r_done_id <= w_win;
            r_gnt0    <= ~w_win;
            r_gnt1    <= w_win;
          end
        end
        S_RUN: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_res <= {w_s, r_res[WIDTH-1:1]};
          r_c   <= w_cn;
          r_cnt <= r_cnt + CW'(1);
          if (w_last_bit) begin
            // Final bit: publish the completed result together with the
            // carry out of the MSB.
            r_sum  <= {w_s, r_res[WIDTH-1:1]};
            r_cout <= w_cn;
            r_done <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign gnt0    = r_gnt0;
  assign gnt1    = r_gnt1;
  assign done    = r_done;
  assign done_id = r_done_id;
  assign sum     = r_sum;
  assign cout    = r_cout;

endmodule
